// File: rtl/ctrl_pipe_unit.sv
// RV32I decode-stage control and the ID/EX, EX/MEM, MEM/WB control pipeline.
// Decodes the base opcodes into a control bundle and carries it down the pipe
// with a valid bit per stage. It also provides:
//   - the load-use interlock (or a full RAW interlock when forwarding is off)
//   - squash of the wrong-path ID instruction on an EX redirect
//   - EX operand forwarding selects
//   - a saturating count of illegal instructions that reach EX
module ctrl_pipe_unit #(
    parameter int REG_AW    = 5,
    parameter int ILL_CNT_W = 8,
    parameter int FWD_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    input  logic                 ex_redirect,
    input  logic                 stall_ext,
    output logic                 id_stall,
    output logic                 id_illegal,
    output logic                 ex_valid,
    output logic [1:0]           ex_alu_op,
    output logic                 ex_alu_src,
    output logic [2:0]           ex_imm_sel,
    output logic                 ex_branch,
    output logic                 ex_jump,
    output logic [REG_AW-1:0]    ex_rs1,
    output logic [REG_AW-1:0]    ex_rs2,
    output logic [REG_AW-1:0]    ex_rd,
    output logic                 mem_valid,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 mem_reg_write,
    output logic [REG_AW-1:0]    mem_rd,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic                 wb_mem_to_reg,
    output logic [REG_AW-1:0]    wb_rd,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [ILL_CNT_W-1:0] ill_count
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
        return (v == {ILL_CNT_W{1'b1}}) ? v : v + ILL_CNT_W'(1);
    endfunction

    // Source-select for one EX operand; MEM result wins over WB result.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic m_en, input logic [REG_AW-1:0] m_rd,
                                           input logic w_en, input logic [REG_AW-1:0] w_rd);
        if (rs == '0) return 2'b00;
        if (m_en && (m_rd == rs)) return 2'b10;
        if (w_en && (w_rd == rs)) return 2'b01;
        return 2'b00;
    endfunction

    // True when the ID instruction reads a register that 'rd' is going to write.
    function automatic logic reads_reg(input logic [REG_AW-1:0] rd,
                                       input logic u1, input logic [REG_AW-1:0] r1,
                                       input logic u2, input logic [REG_AW-1:0] r2);
        return (rd != '0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
    endfunction

    logic [6:0]        opcode;
    logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
    logic              dec_legal, dec_mem_read, dec_mem_write, dec_mem_to_reg;
    logic              dec_reg_write, dec_alu_src, dec_branch, dec_jump;
    logic              dec_uses_rs1, dec_uses_rs2;
    logic [1:0]        dec_alu_op;
    logic [2:0]        dec_imm_sel;
    logic              ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic              hazard, redirect_take, id_ill_raw;

    assign opcode = id_instr[6:0];
    assign id_rd  = REG_AW'(id_instr[11:7]);
    assign id_rs1 = REG_AW'(id_instr[19:15]);
    assign id_rs2 = REG_AW'(id_instr[24:20]);

    // Opcode decode into the control bundle; unknown opcodes decode to all zeros.
    always_comb begin
        dec_legal      = 1'b1;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_alu_op     = 2'b00;
        dec_imm_sel    = 3'd0;
        dec_uses_rs1   = 1'b1;
        dec_uses_rs2   = 1'b0;
        case (opcode)
            OP_LOAD:   begin dec_mem_read = 1'b1; dec_reg_write = 1'b1; dec_mem_to_reg = 1'b1; dec_alu_src = 1'b1; end
            OP_STORE:  begin dec_mem_write = 1'b1; dec_alu_src = 1'b1; dec_imm_sel = 3'd1; dec_uses_rs2 = 1'b1; end
            OP_BRANCH: begin dec_branch = 1'b1; dec_alu_op = 2'b01; dec_imm_sel = 3'd2; dec_uses_rs2 = 1'b1; end
            OP_IMM:    begin dec_reg_write = 1'b1; dec_alu_op = 2'b10; dec_alu_src = 1'b1; end
            OP_REG:    begin dec_reg_write = 1'b1; dec_alu_op = 2'b10; dec_uses_rs2 = 1'b1; end
            OP_LUI:    begin dec_reg_write = 1'b1; dec_alu_op = 2'b11; dec_alu_src = 1'b1; dec_imm_sel = 3'd3; dec_uses_rs1 = 1'b0; end
            OP_AUIPC:  begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_imm_sel = 3'd3; dec_uses_rs1 = 1'b0; end
            OP_JAL:    begin dec_reg_write = 1'b1; dec_jump = 1'b1; dec_imm_sel = 3'd4; dec_uses_rs1 = 1'b0; end
            OP_JALR:   begin dec_reg_write = 1'b1; dec_jump = 1'b1; dec_alu_src = 1'b1; end
            default:   begin dec_legal = 1'b0; dec_uses_rs1 = 1'b0; end
        endcase
        // Writes to x0 are dropped at decode so nothing downstream forwards them.
        if (id_rd == '0) dec_reg_write = 1'b0;
    end

    // Interlock: with forwarding only a load in EX stalls; without it any in-flight writer does.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = id_valid && ex_valid && ex_mem_read &&
                     reads_reg(ex_rd, dec_uses_rs1, id_rs1, dec_uses_rs2, id_rs2);
        end else begin
            hazard = id_valid && (
                     (ex_valid  && ex_reg_write  && reads_reg(ex_rd,  dec_uses_rs1, id_rs1, dec_uses_rs2, id_rs2)) ||
                     (mem_valid && mem_reg_write && reads_reg(mem_rd, dec_uses_rs1, id_rs1, dec_uses_rs2, id_rs2)) ||
                     (wb_valid  && wb_reg_write  && reads_reg(wb_rd,  dec_uses_rs1, id_rs1, dec_uses_rs2, id_rs2)));
        end
    end

    assign redirect_take = ex_redirect & ex_valid;
    assign id_ill_raw    = id_valid & ~dec_legal;
    // Combinational outputs are held low while reset is asserted.
    assign id_stall      = rst_n & (stall_ext | (hazard & ~redirect_take));
    assign id_illegal    = rst_n & id_ill_raw;

    // Forwarding selects; a load in MEM has no result yet, so it is not a source.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN != 0) begin
            fwd_a = fwd_sel(ex_rs1, mem_valid & mem_reg_write & ~mem_read, mem_rd, wb_valid & wb_reg_write, wb_rd);
            fwd_b = fwd_sel(ex_rs2, mem_valid & mem_reg_write & ~mem_read, mem_rd, wb_valid & wb_reg_write, wb_rd);
        end
    end

    // Stage registers: freeze on external stall, bubble EX on redirect or hazard, else advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;  ex_alu_op    <= 2'b00; ex_alu_src    <= 1'b0;
            ex_imm_sel    <= 3'd0;  ex_branch    <= 1'b0;  ex_jump       <= 1'b0;
            ex_rs1        <= '0;    ex_rs2       <= '0;    ex_rd         <= '0;
            ex_mem_read   <= 1'b0;  ex_mem_write <= 1'b0;  ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            mem_valid     <= 1'b0;  mem_read     <= 1'b0;  mem_write     <= 1'b0;
            mem_to_reg    <= 1'b0;  mem_reg_write <= 1'b0; mem_rd        <= '0;
            wb_valid      <= 1'b0;  wb_reg_write <= 1'b0;  wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            ill_count     <= '0;
        end else if (!stall_ext) begin
            mem_valid     <= ex_valid;
            mem_read      <= ex_mem_read;
            mem_write     <= ex_mem_write;
            mem_to_reg    <= ex_mem_to_reg;
            mem_reg_write <= ex_reg_write;
            mem_rd        <= ex_rd;
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_to_reg;
            wb_rd         <= mem_rd;
            if (redirect_take || hazard) begin
                ex_valid      <= 1'b0;  ex_alu_op    <= 2'b00; ex_alu_src    <= 1'b0;
                ex_imm_sel    <= 3'd0;  ex_branch    <= 1'b0;  ex_jump       <= 1'b0;
                ex_rs1        <= '0;    ex_rs2       <= '0;    ex_rd         <= '0;
                ex_mem_read   <= 1'b0;  ex_mem_write <= 1'b0;  ex_mem_to_reg <= 1'b0;
                ex_reg_write  <= 1'b0;
            end else begin
                ex_valid      <= id_valid;
                ex_alu_op     <= dec_alu_op  & {2{id_valid}};
                ex_alu_src    <= dec_alu_src & id_valid;
                ex_imm_sel    <= dec_imm_sel & {3{id_valid}};
                ex_branch     <= dec_branch  & id_valid;
                ex_jump       <= dec_jump    & id_valid;
                ex_rs1        <= id_rs1;
                ex_rs2        <= id_rs2;
                ex_rd         <= id_rd;
                ex_mem_read   <= dec_mem_read   & id_valid;
                ex_mem_write  <= dec_mem_write  & id_valid;
                ex_mem_to_reg <= dec_mem_to_reg & id_valid;
                ex_reg_write  <= dec_reg_write  & id_valid;
                if (id_ill_raw) ill_count <= sat_inc(ill_count);
            end
        end
    end
endmodule
